match_sequencer: RTL and testbench

//  Match-level controller for the 1v1 arena: owns scores, round restarts and gameplay freeze.

---
 rtl/game_pkg.sv | 58 +++++
 rtl/frame_edge_detect.sv | 18 +
 rtl/match_sequencer.sv | 164 ++++++++++++++++
 tb/tb_match_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared match/game definitions: state and winner encodings, widths, keycodes.
package game_pkg;

  localparam int unsigned STATE_W  = 3;
  localparam int unsigned SCORE_W  = 4;
  localparam int unsigned KEY_W    = 8;
  localparam int unsigned FREEZE_W = 8;
  localparam int unsigned RESET_W  = 4;
  localparam int unsigned TIME_W   = 12;

  typedef enum logic [STATE_W-1:0] {
    MS_IDLE   = 3'd0,
    MS_RRESET = 3'd1,
    MS_PLAY   = 3'd2,
    MS_HIT    = 3'd3,
    MS_OVER   = 3'd4
  } match_state_t;

  localparam logic [STATE_W-1:0] ST_IDLE   = MS_IDLE;
  localparam logic [STATE_W-1:0] ST_RRESET = MS_RRESET;
  localparam logic [STATE_W-1:0] ST_PLAY   = MS_PLAY;
  localparam logic [STATE_W-1:0] ST_HIT    = MS_HIT;
  localparam logic [STATE_W-1:0] ST_OVER   = MS_OVER;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_t;

  // USB HID keycodes shared with shot detection
  localparam logic [KEY_W-1:0] KEY_SPACE = 8'h2C;
  localparam logic [KEY_W-1:0] KEY_RIGHT = 8'h4F;
  localparam logic [KEY_W-1:0] KEY_LEFT  = 8'h50;
  localparam logic [KEY_W-1:0] KEY_DOWN  = 8'h51;
  localparam logic [KEY_W-1:0] KEY_UP    = 8'h52;
  localparam logic [KEY_W-1:0] KEY_I     = 8'h0C;
  localparam logic [KEY_W-1:0] KEY_J     = 8'h0D;
  localparam logic [KEY_W-1:0] KEY_K     = 8'h0E;
  localparam logic [KEY_W-1:0] KEY_L     = 8'h0F;

  function automatic logic [1:0] winner_of(input logic [SCORE_W-1:0] s1,
                                           input logic [SCORE_W-1:0] s2,
                                           input logic [SCORE_W-1:0] win);
    logic p1_won;
    logic p2_won;
    p1_won = (s1 == win);
    p2_won = (s2 == win);
    case ({p2_won, p1_won})
      2'b01:   winner_of = WIN_P1;
      2'b10:   winner_of = WIN_P2;
      2'b11:   winner_of = WIN_DRAW;
      default: winner_of = WIN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/frame_edge_detect.sv
// One-bit rising-edge detector on the frame strobe; history updates every frame.
module frame_edge_detect (
  input  logic frame_clk,
  input  logic reset_ah,
  input  logic sig_i,
  output logic rise_c
);

  logic prev_q;

  always_ff @(posedge frame_clk or posedge reset_ah) begin
    if (reset_ah) prev_q <= 1'b0;
    else          prev_q <= sig_i;
  end

  assign rise_c = sig_i & ~prev_q;

endmodule

// File: rtl/match_sequencer.sv
// Match-level controller: scores, round restarts and gameplay freeze on the frame strobe.
// Define MATCH_ROUND_TIMER_EN to add the per-round PLAY time limit driving time_left.
module match_sequencer
  import game_pkg::*;
#(
  parameter logic [SCORE_W-1:0]  WIN_SCORE     = 4'd9,
  parameter logic [FREEZE_W-1:0] FREEZE_FRAMES = 8'd60,
  parameter logic [RESET_W-1:0]  RESET_FRAMES  = 4'd2,
  parameter logic [KEY_W-1:0]    START_KEY     = KEY_SPACE
`ifdef MATCH_ROUND_TIMER_EN
  ,
  parameter logic [TIME_W-1:0]   ROUND_FRAMES  = 12'd1800
`endif
) (
  input  logic               frame_clk,
  input  logic               reset_ah,
  input  logic               hit_p1,
  input  logic               hit_p2,
  input  logic [KEY_W-1:0]   keycode,
  output logic               round_reset,
  output logic               freeze,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic [1:0]         winner,
  output logic [STATE_W-1:0] state,
  output logic [TIME_W-1:0]  time_left
);

  logic p1_rise_c, p2_rise_c, start_c, key_match_c;

  logic [STATE_W-1:0]  state_q, state_d;
  logic [RESET_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [FREEZE_W-1:0] frz_cnt_q, frz_cnt_d;
  logic [SCORE_W-1:0]  score_p1_q, score_p1_d, score_p2_q, score_p2_d;
  logic [1:0]          winner_q, winner_d;
  logic                round_reset_q, round_reset_d;
  logic                freeze_q, freeze_d;
`ifdef MATCH_ROUND_TIMER_EN
  logic [TIME_W-1:0]   time_q, time_d;
`endif

  assign key_match_c = (keycode == START_KEY);

  frame_edge_detect u_edge_p1 (.frame_clk(frame_clk), .reset_ah(reset_ah), .sig_i(hit_p1),      .rise_c(p1_rise_c));
  frame_edge_detect u_edge_p2 (.frame_clk(frame_clk), .reset_ah(reset_ah), .sig_i(hit_p2),      .rise_c(p2_rise_c));
  frame_edge_detect u_edge_st (.frame_clk(frame_clk), .reset_ah(reset_ah), .sig_i(key_match_c), .rise_c(start_c));

  // Next-state and registered-output decode; counters reload on state entry.
  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    frz_cnt_d  = frz_cnt_q;
    score_p1_d = score_p1_q;
    score_p2_d = score_p2_q;
    winner_d   = winner_q;
`ifdef MATCH_ROUND_TIMER_EN
    time_d     = time_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          state_d   = ST_RRESET;
          rst_cnt_d = RESET_FRAMES - 4'd1;
        end
      end
      ST_RRESET: begin
        if (rst_cnt_q == '0) begin
          state_d = ST_PLAY;
`ifdef MATCH_ROUND_TIMER_EN
          time_d  = ROUND_FRAMES;
`endif
        end else begin
          rst_cnt_d = rst_cnt_q - 4'd1;
        end
      end
      ST_PLAY: begin
`ifdef MATCH_ROUND_TIMER_EN
        if (time_q != '0) time_d = time_q - 12'd1;
`endif
        if (p1_rise_c || p2_rise_c) begin
          state_d   = ST_HIT;
          frz_cnt_d = FREEZE_FRAMES - 8'd1;
          if (p2_rise_c && (score_p1_q < WIN_SCORE)) score_p1_d = score_p1_q + 4'd1;
          if (p1_rise_c && (score_p2_q < WIN_SCORE)) score_p2_d = score_p2_q + 4'd1;
        end
`ifdef MATCH_ROUND_TIMER_EN
        // A hit on the expiry frame takes priority over the timeout
        else if (time_q <= 12'd1) begin
          state_d   = ST_RRESET;
          rst_cnt_d = RESET_FRAMES - 4'd1;
        end
`endif
      end
      ST_HIT: begin
        if (frz_cnt_q == '0) begin
          if ((score_p1_q == WIN_SCORE) || (score_p2_q == WIN_SCORE)) begin
            state_d  = ST_OVER;
            winner_d = winner_of(score_p1_q, score_p2_q, WIN_SCORE);
          end else begin
            state_d   = ST_RRESET;
            rst_cnt_d = RESET_FRAMES - 4'd1;
          end
        end else begin
          frz_cnt_d = frz_cnt_q - 8'd1;
        end
      end
      ST_OVER: begin
        if (start_c) begin
          state_d    = ST_RRESET;
          rst_cnt_d  = RESET_FRAMES - 4'd1;
          score_p1_d = '0;
          score_p2_d = '0;
          winner_d   = WIN_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    round_reset_d = (state_d == ST_RRESET);
    freeze_d      = (state_d != ST_PLAY);
  end

  always_ff @(posedge frame_clk or posedge reset_ah) begin
    if (reset_ah) begin
      state_q       <= ST_IDLE;
      rst_cnt_q     <= '0;
      frz_cnt_q     <= '0;
      score_p1_q    <= '0;
      score_p2_q    <= '0;
      winner_q      <= WIN_NONE;
      round_reset_q <= 1'b0;
      freeze_q      <= 1'b1;
`ifdef MATCH_ROUND_TIMER_EN
      time_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      frz_cnt_q     <= frz_cnt_d;
      score_p1_q    <= score_p1_d;
      score_p2_q    <= score_p2_d;
      winner_q      <= winner_d;
      round_reset_q <= round_reset_d;
      freeze_q      <= freeze_d;
`ifdef MATCH_ROUND_TIMER_EN
      time_q        <= time_d;
`endif
    end
  end

  assign state       = state_q;
  assign round_reset = round_reset_q;
  assign freeze      = freeze_q;
  assign score_p1    = score_p1_q;
  assign score_p2    = score_p2_q;
  assign winner      = winner_q;
`ifdef MATCH_ROUND_TIMER_EN
  assign time_left   = time_q;
`else
  assign time_left   = '0;
`endif

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer: per-frame model comparison plus literal checkpoints.
module tb_match_sequencer;
  import game_pkg::*;

  localparam int WIN = 9;
  localparam int FRZ = 60;
  localparam int RST = 2;
`ifdef MATCH_ROUND_TIMER_EN
  localparam bit TIMER = 1'b1;
  localparam int ROUND = 10;
`else
  localparam bit TIMER = 1'b0;
  localparam int ROUND = 0;
`endif

  logic        frame_clk, reset_ah, hit_p1, hit_p2;
  logic [7:0]  keycode;
  logic        round_reset, freeze;
  logic [3:0]  score_p1, score_p2;
  logic [1:0]  winner;
  logic [2:0]  state;
  logic [11:0] time_left;

  match_sequencer #(
    .WIN_SCORE(4'd9)
`ifdef MATCH_ROUND_TIMER_EN
    , .ROUND_FRAMES(12'd10)
`endif
  ) dut (
    .frame_clk(frame_clk), .reset_ah(reset_ah), .hit_p1(hit_p1), .hit_p2(hit_p2),
    .keycode(keycode), .round_reset(round_reset), .freeze(freeze),
    .score_p1(score_p1), .score_p2(score_p2), .winner(winner), .state(state),
    .time_left(time_left)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  int n_total = 0;
  int n_pass  = 0;
  bit cmp_en  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: phases measured as frames remaining, scores as plain integers
  logic [2:0] m_state;
  int m_left, m_s1, m_s2, m_win, m_time;
  bit mp1, mp2, mpk;

  task automatic model_reset();
    m_state = ST_IDLE; m_left = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_time = 0;
    mp1 = 0; mp2 = 0; mpk = 0;
  endtask

  task automatic go_rreset();
    m_state = ST_RRESET;
    m_left  = RST;
  endtask

  task automatic model_step();
    bit r1, r2, st;
    r1 = hit_p1 && !mp1;
    r2 = hit_p2 && !mp2;
    st = (keycode == 8'h2C) && !mpk;
    mp1 = hit_p1; mp2 = hit_p2; mpk = (keycode == 8'h2C);
    case (m_state)
      ST_IDLE: if (st) go_rreset();
      ST_RRESET: begin
        m_left--;
        if (m_left == 0) begin m_state = ST_PLAY; m_time = ROUND; end
      end
      ST_PLAY: begin
        if (TIMER && m_time > 0) m_time--;
        if (r1 || r2) begin
          if (r2) m_s1 = (m_s1 + 1 > WIN) ? WIN : m_s1 + 1;
          if (r1) m_s2 = (m_s2 + 1 > WIN) ? WIN : m_s2 + 1;
          m_state = ST_HIT;
          m_left  = FRZ;
        end else if (TIMER && m_time == 0) go_rreset();
      end
      ST_HIT: begin
        m_left--;
        if (m_left == 0) begin
          if (m_s1 == WIN || m_s2 == WIN) begin
            m_state = ST_OVER;
            m_win = ((m_s1 == WIN) ? 1 : 0) + ((m_s2 == WIN) ? 2 : 0);
          end else go_rreset();
        end
      end
      ST_OVER: if (st) begin m_s1 = 0; m_s2 = 0; m_win = 0; go_rreset(); end
      default: m_state = ST_IDLE;
    endcase
  endtask

  // Per-frame comparison of every output against the model
  always @(negedge frame_clk) begin
    if (cmp_en && !reset_ah) begin
      chk("state",       int'(state),       int'(m_state));
      chk("round_reset", int'(round_reset), int'(m_state == ST_RRESET));
      chk("freeze",      int'(freeze),      int'(m_state != ST_PLAY));
      chk("score_p1",    int'(score_p1),    m_s1);
      chk("score_p2",    int'(score_p2),    m_s2);
      chk("winner",      int'(winner),      m_win);
      chk("time_left",   int'(time_left),   m_time);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge frame_clk);
      model_step();
      @(negedge frame_clk);
      #1;
    end
  endtask

  task automatic wait_model(input logic [2:0] target, input string name);
    int n = 0;
    while (m_state != target && n < 200) begin step(1); n++; end
    chk(name, int'(m_state == target), 1);
  endtask

  task automatic wait_leave_hit(input string name);
    int n = 0;
    while (m_state == ST_HIT && n < 200) begin step(1); n++; end
    chk(name, int'(m_state != ST_HIT), 1);
  endtask

  task automatic play_round(input bit h1, input bit h2);
    wait_model(ST_PLAY, "reach_play");
    hit_p1 = h1; hit_p2 = h2;
    step(1);
    hit_p1 = 0; hit_p2 = 0;
    wait_leave_hit("leave_hit");
  endtask

  task automatic restart_from_over();
    keycode = 8'h00; step(1);
    keycode = 8'h2C; step(1);
    keycode = 8'h00;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    reset_ah = 1; hit_p1 = 0; hit_p2 = 0; keycode = 8'h00;
    model_reset();
    #1;
    chk("rst_state",  int'(state), 0);
    chk("rst_freeze", int'(freeze), 1);
    chk("rst_rr",     int'(round_reset), 0);
    chk("rst_scores", int'({score_p1, score_p2}), 0);
    chk("rst_winner", int'(winner), 0);
    chk("rst_time",   int'(time_left), 0);
    repeat (2) @(negedge frame_clk);
    #1 reset_ah = 0;
    cmp_en = 1;
    step(2);

    // Hits in IDLE are ignored
    hit_p2 = 1; step(1); hit_p2 = 0;
    chk("idle_hit_state", int'(state), 0);
    chk("idle_hit_score", int'(score_p1), 0);

    // Start key: two RRESET frames, then PLAY unfrozen
    keycode = 8'h2C; step(1); keycode = 8'h00;
    chk("start_rreset", int'(state), 1);
    chk("start_rr1",    int'(round_reset), 1);
    step(1);
    chk("start_rr2",    int'(round_reset), 1);
    step(1);
    chk("start_play",   int'(state), 2);
    chk("start_rr_off", int'(round_reset), 0);
    chk("start_unfrz",  int'(freeze), 0);

    // hit_p2 held 5 frames scores once; HIT lasts 60 frames
    hit_p2 = 1; step(1);
    chk("hit_state", int'(state), 3);
    chk("hit_score", int'(score_p1), 1);
    n = 1;
    for (int i = 0; i < 100; i++) begin
      if (n == 5) hit_p2 = 0;
      step(1);
      if (state != 3'd3) break;
      n++;
    end
    hit_p2 = 0;
    chk("hit_frames",   n, 60);
    chk("hit_to_rr",    int'(state), 1);
    chk("hit_once",     int'(score_p1), 1);
    wait_model(ST_PLAY, "replay");

    // Start key during PLAY is ignored
    keycode = 8'h2C; step(1); keycode = 8'h00;
    chk("play_start_ign", int'(state), 2);

    play_round(1, 0);
    chk("p1_hit_score", int'(score_p2), 1);
    for (int r = 0; r < 7; r++) play_round(1, 1);
    chk("trade_8_8", int'({score_p1, score_p2}), 8'h88);

    // Simultaneous rise at 8-8: draw; start key held across OVER entry
    wait_model(ST_PLAY, "reach_play_final");
    hit_p1 = 1; hit_p2 = 1; step(1);
    hit_p1 = 0; hit_p2 = 0;
    chk("draw_scores", int'({score_p1, score_p2}), 8'h99);
    keycode = 8'h2C;
    wait_leave_hit("draw_leave");
    chk("draw_over",   int'(state), 4);
    chk("draw_winner", int'(winner), 3);
    step(3);
    chk("held_key_no_restart", int'(state), 4);
    restart_from_over();
    chk("restart_state",  int'(state), 1);
    chk("restart_scores", int'({score_p1, score_p2}), 0);
    chk("restart_winner", int'(winner), 0);

    // Reach 3-2 and reset mid-HIT
    for (int r = 0; r < 3; r++) play_round(0, 1);
    play_round(1, 0);
    wait_model(ST_PLAY, "reach_play_32");
    hit_p1 = 1; step(1); hit_p1 = 0;
    chk("pre_rst_scores", int'({score_p1, score_p2}), 8'h32);
    step(5);
    reset_ah = 1;
    model_reset();
    #1;
    chk("midrst_state",  int'(state), 0);
    chk("midrst_scores", int'({score_p1, score_p2}), 0);
    chk("midrst_freeze", int'(freeze), 1);
    chk("midrst_rr",     int'(round_reset), 0);
    #1 reset_ah = 0;
    step(3);
    chk("post_rst_idle", int'(state), 0);
    chk("post_rst_rr",   int'(round_reset), 0);

    // Player 1 solo win
    keycode = 8'h2C; step(1); keycode = 8'h00;
    for (int r = 0; r < 9; r++) play_round(0, 1);
    chk("p1win_state",  int'(state), 4);
    chk("p1win_winner", int'(winner), 1);
    chk("p1win_scores", int'({score_p1, score_p2}), 8'h90);

`ifdef MATCH_ROUND_TIMER_EN
    // Round timeout with no hits
    restart_from_over();
    wait_model(ST_PLAY, "timer_play");
    chk("timer_load", int'(time_left), 10);
    n = 1;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (state != 3'd2) break;
      n++;
    end
    chk("timer_frames", n, 10);
    chk("timer_rr",     int'(state), 1);
    chk("timer_scores", int'({score_p1, score_p2}), 0);
`endif

    step(2);
    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
